// File: rtl/dvi_timing_sequencer.sv
// DVI raster timing generator and pixel sequencer feeding three TMDS encoders.
// Optional colour-bar generator is compiled in with `define DVI_TEST_PATTERN_EN.
module dvi_timing_sequencer #(
    parameter int   H_ACTIVE  = 640,
    parameter int   H_FP      = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BP      = 48,
    parameter int   V_ACTIVE  = 480,
    parameter int   V_FP      = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BP      = 33,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    parameter int   CW        = 12
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
`ifdef DVI_TEST_PATTERN_EN
    input  logic          test_mode,
`endif
    input  logic          pix_valid,
    input  logic [23:0]   pix_data,
    output logic          pix_ready,
    output logic          de,
    output logic          hsync,
    output logic          vsync,
    output logic [23:0]   rgb,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          frame_start,
    output logic          underflow,
    input  logic          underflow_clr
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_ACT_END  = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] H_FP_END   = CW'(H_ACTIVE + H_FP - 1);
    localparam logic [CW-1:0] H_SYNC_END = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_ACT_END  = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] V_FP_END   = CW'(V_ACTIVE + V_FP - 1);
    localparam logic [CW-1:0] V_SYNC_END = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);

    typedef enum logic [1:0] {HS_ACT, HS_FP, HS_SYNC, HS_BP} h_state_t;
    typedef enum logic [1:0] {VS_ACT, VS_FP, VS_SYNC, VS_BP} v_state_t;

    h_state_t       h_state_q, h_state_d;
    v_state_t       v_state_q, v_state_d;
    logic [CW-1:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [CW-1:0]  x_q, x_d, y_q, y_d;
    logic [23:0]    rgb_q, rgb_d;
    logic           de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic           frame_start_q, frame_start_d, underflow_q, underflow_d;
    logic           h_wrap, v_wrap, active_w;

`ifdef DVI_TEST_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
    logic [2:0]  bar_idx;
    logic [23:0] bar_rgb;

    // Bar order white..black maps each colour channel onto one index bit.
    always_comb begin
        bar_idx = 3'(h_cnt_q / CW'(BAR_W));
        bar_rgb = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
    end
`endif

    // Raster counters and the two phase state machines.
    always_comb begin
        h_wrap    = (h_cnt_q == H_LAST);
        v_wrap    = (v_cnt_q == V_LAST);
        h_cnt_d   = h_wrap ? '0 : h_cnt_q + CW'(1);
        v_cnt_d   = h_wrap ? (v_wrap ? '0 : v_cnt_q + CW'(1)) : v_cnt_q;
        h_state_d = h_state_q;
        v_state_d = v_state_q;
        case (h_state_q)
            HS_ACT:  if (h_cnt_q == H_ACT_END)  h_state_d = HS_FP;
            HS_FP:   if (h_cnt_q == H_FP_END)   h_state_d = HS_SYNC;
            HS_SYNC: if (h_cnt_q == H_SYNC_END) h_state_d = HS_BP;
            HS_BP:   if (h_wrap)                h_state_d = HS_ACT;
            default:                            h_state_d = HS_ACT;
        endcase
        if (h_wrap) begin
            case (v_state_q)
                VS_ACT:  if (v_cnt_q == V_ACT_END)  v_state_d = VS_FP;
                VS_FP:   if (v_cnt_q == V_FP_END)   v_state_d = VS_SYNC;
                VS_SYNC: if (v_cnt_q == V_SYNC_END) v_state_d = VS_BP;
                VS_BP:   if (v_wrap)                v_state_d = VS_ACT;
                default:                            v_state_d = VS_ACT;
            endcase
        end
        if (!enable) begin
            h_cnt_d   = '0;
            v_cnt_d   = '0;
            h_state_d = HS_ACT;
            v_state_d = VS_ACT;
        end
    end

    // Output stage: everything here lands on the encoders one clock later.
    always_comb begin
        active_w = enable && (h_state_q == HS_ACT) && (v_state_q == VS_ACT);
`ifdef DVI_TEST_PATTERN_EN
        pix_ready = active_w && !test_mode;
`else
        pix_ready = active_w;
`endif
        de_d          = active_w;
        frame_start_d = active_w && (h_cnt_q == '0) && (v_cnt_q == '0);
        hsync_d       = (enable && h_state_q == HS_SYNC) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d       = (enable && v_state_q == VS_SYNC) ? VSYNC_POL : ~VSYNC_POL;
        x_d           = !enable ? '0 : (active_w ? h_cnt_q : x_q);
        y_d           = !enable ? '0 : (active_w ? v_cnt_q : y_q);
        rgb_d         = (pix_ready && pix_valid) ? pix_data : 24'h0;
`ifdef DVI_TEST_PATTERN_EN
        if (active_w && test_mode) rgb_d = bar_rgb;
`endif
        // A starved pixel wins over a same-cycle clear so no event is lost.
        if (pix_ready && !pix_valid) underflow_d = 1'b1;
        else if (underflow_clr)      underflow_d = 1'b0;
        else                         underflow_d = underflow_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_state_q     <= HS_ACT;
            v_state_q     <= VS_ACT;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            x_q           <= '0;
            y_q           <= '0;
            rgb_q         <= '0;
            de_q          <= 1'b0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            h_state_q     <= h_state_d;
            v_state_q     <= v_state_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            x_q           <= x_d;
            y_q           <= y_d;
            rgb_q         <= rgb_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
        end
    end

    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign rgb         = rgb_q;
    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_dvi_timing_sequencer.sv
// Randomised bench for dvi_timing_sequencer on a tiny raster; the reference
// model tracks a linear position inside the frame and derives (h,v) arithmetically.
module tb_dvi_timing_sequencer;

`ifdef DVI_TEST_PATTERN_EN
    localparam int HA = 8;
`else
    localparam int HA = 4;
`endif
    localparam int HFP = 1, HSW = 2, HBP = 1;
    localparam int VA = 3, VFP = 1, VSW = 1, VBP = 1;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;
    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          en, pv, clr, tm;
    logic [23:0]   pd;
    logic          pix_ready, de, hsync, vsync, frame_start, underflow;
    logic [23:0]   rgb;
    logic [CW-1:0] x, y;

    int total = 0;
    int bad = 0;

    // reference model state
    int          pos;
    logic        e_de, e_hs, e_vs, e_fs, e_uf;
    logic [23:0] e_rgb;
    int          e_x, e_y;
    logic        last_xfer;
    logic [23:0] bars [8];

    dvi_timing_sequencer #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CW(CW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(en),
`ifdef DVI_TEST_PATTERN_EN
        .test_mode(tm),
`endif
        .pix_valid(pv),
        .pix_data(pd),
        .pix_ready(pix_ready),
        .de(de),
        .hsync(hsync),
        .vsync(vsync),
        .rgb(rgb),
        .x(x),
        .y(y),
        .frame_start(frame_start),
        .underflow(underflow),
        .underflow_clr(clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("de", 32'(de), 32'(e_de));
        check("hsync", 32'(hsync), 32'(e_hs));
        check("vsync", 32'(vsync), 32'(e_vs));
        check("rgb", 32'(rgb), 32'(e_rgb));
        check("x", 32'(x), e_x);
        check("y", 32'(y), e_y);
        check("frame_start", 32'(frame_start), 32'(e_fs));
        check("underflow", 32'(underflow), 32'(e_uf));
    endtask

    task automatic model_reset();
        pos = 0;
        e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0; e_uf = 1'b0;
        e_rgb = 24'h0; e_x = 0; e_y = 0;
    endtask

    // One pixel clock: inputs are already driven by the caller.
    task automatic step();
        int h, v;
        logic act, rdy;
        @(negedge clk);
        h   = pos % HT;
        v   = pos / HT;
        act = en && (h < HA) && (v < VA);
        rdy = act && !tm;
        check("pix_ready", 32'(pix_ready), 32'(rdy));
        e_de  = act;
        e_fs  = act && (pos == 0);
        e_hs  = !(en && h >= HA + HFP && h < HA + HFP + HSW);
        e_vs  = !(en && v >= VA + VFP && v < VA + VFP + VSW);
        e_rgb = (rdy && pv) ? pd : 24'h0;
        if (act && tm) e_rgb = bars[(h / (HA / 8 > 0 ? HA / 8 : 1)) % 8];
        if (act) begin e_x = h; e_y = v; end
        if (!en) begin e_x = 0; e_y = 0; end
        if (rdy && !pv)  e_uf = 1'b1;
        else if (clr)    e_uf = 1'b0;
        last_xfer = rdy && pv;
        if (last_xfer) $display("xfer x=%0d y=%0d data=%06h", h, v, pd);
        pos = en ? (pos + 1) % FRAME : 0;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
        bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;
        reset_n = 1'b0; en = 1'b0; pv = 1'b0; clr = 1'b0; tm = 1'b0; pd = 24'h0;
        model_reset();
        #12;
        check_outputs();
        @(posedge clk); #1;
        reset_n = 1'b1;
        step(); step();

        // incrementing data, two full frames
        en = 1'b1; pv = 1'b1; pd = 24'h0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            if (last_xfer) pd = pd + 24'h1;
        end

        // starve pixel (2,1), then clear; second pass clears in the same cycle
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < FRAME; i++) begin
                pv  = !(pos == HT + 2);
                clr = (pass == 1) ? (pos == HT + 2) : (pos == 2 * HT + 1);
                pd  = $urandom;
                step();
            end
            pv = 1'b1; clr = 1'b1; step(); clr = 1'b0;
        end

        // drop enable at (3,1), restart from (0,0)
        for (int i = 0; i < FRAME && pos != HT + 3; i++) begin
            pd = $urandom; step();
        end
        en = 1'b0; step(); step(); step();
        en = 1'b1;
        for (int i = 0; i < FRAME + 4; i++) begin
            pd = $urandom; step();
        end

        // random traffic
        for (int i = 0; i < 600; i++) begin
            en  = ($urandom_range(0, 40) != 0);
            pv  = ($urandom_range(0, 7) != 0);
            clr = ($urandom_range(0, 15) == 0);
            pd  = $urandom;
            step();
        end
        en = 1'b1; pv = 1'b1; clr = 1'b0;

        // asynchronous reset mid-line
        for (int i = 0; i < FRAME && pos != HT + 2; i++) begin
            pd = $urandom; step();
        end
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(posedge clk); #1;
        check_outputs();
        reset_n = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            pd = $urandom; step();
        end

`ifdef DVI_TEST_PATTERN_EN
        tm = 1'b1;
        for (int i = 0; i < FRAME + 3; i++) begin
            pv = $urandom_range(0, 1); pd = $urandom; step();
        end
        tm = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dvi_timing_sequencer.md
# dvi_timing_sequencer

Sequences the three per-channel `dvi_tmds_encoder` instances. It generates the raster timing and drives each encoder's `DE`, `C0` and `C1` inputs. It also pulls 24-bit RGB pixels from the upstream spectrogram frame source over a valid/ready handshake and presents them to the encoders' `D` inputs, aligned with `DE`. Upstream starvation is reported as a sticky underflow flag.

## Interface
- `H_ACTIVE`, 640, active pixels per line
- `H_FP`, 16, horizontal front porch, in clocks
- `H_SYNC`, 96, hsync width, in clocks
- `H_BP`, 48, horizontal back porch, in clocks
- `V_ACTIVE`, 480, active lines
- `V_FP`, 10, vertical front porch, in lines
- `V_SYNC`, 2, vsync width, in lines
- `V_BP`, 33, vertical back porch, in lines
- `HSYNC_POL`, 0, asserted level of hsync
- `VSYNC_POL`, 0, asserted level of vsync
- `CW`, 12, width of the counters and of `x`/`y`

Ports:
- `clk` in 1: pixel clock, shared with the encoders
- `reset_n` in 1: asynchronous, active-low reset
- `enable` in 1: run the raster; when low, hold in idle
- `pix_valid` in 1: upstream pixel available
- `pix_data` in 24: {R,G,B}, 8 bits each
- `pix_ready` out 1: combinational; a pixel transfers when `pix_valid & pix_ready`
- `de` out 1: to `DE` of all three encoders
- `hsync` out 1: to `C0` of the blue-channel encoder
- `vsync` out 1: to `C1` of the blue-channel encoder
- `rgb` out 24: to `D` of the R, G and B encoders
- `x` out CW: pixel column, aligned with `de`
- `y` out CW: line number, aligned with `de`
- `frame_start` out 1: one-cycle pulse, coincident with pixel (0,0)
- `underflow` out 1: sticky flag
- `underflow_clr` in 1: clears `underflow`

## Operation
- Totals: `H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP` and `V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP`.
- Counters: `h_cnt` runs 0..H_TOTAL-1. `v_cnt` increments when `h_cnt` wraps, and wraps at V_TOTAL-1 to 0.
- Horizontal state machine, advanced by `h_cnt`: H_ACT (0..H_ACTIVE-1) -> H_FP -> H_SYNC -> H_BP -> H_ACT.
- Vertical state machine: V_ACT -> V_FP -> V_SYNC -> V_BP -> V_ACT. Transitions happen only at an `h_cnt` wrap, so vsync edges coincide with line starts.
- Active region: H_ACT and V_ACT. While `enable=1` in the active region, `pix_ready=1`; otherwise `pix_ready=0`.
- Pixel transfer:
  - If `pix_valid=1`, the pixel is taken and registered to `rgb`.
  - If `pix_valid=0` while `pix_ready=1`, `rgb` is driven 0 for that pixel and `underflow` sets. The raster is never stalled.
- Sync outputs:
  - `hsync` equals HSYNC_POL in H_SYNC and ~HSYNC_POL elsewhere.
  - `vsync` equals VSYNC_POL for every clock of V_SYNC lines and ~VSYNC_POL elsewhere.
- Blanking: outside the active region, `de=0` and `rgb=0`. `x` and `y` hold their last active value.
- `enable=0`: on the next edge the counters go to (0,0) and the outputs take their reset values. When `enable` returns to 1, the raster restarts at (0,0), including mid-frame.
- `underflow`:
  - Set has priority over `underflow_clr` in the same cycle.
  - The flag is cleared only by `underflow_clr` or by reset.

## Timing
- Reset values: `de=0`, `hsync=~HSYNC_POL`, `vsync=~VSYNC_POL`, `rgb=0`, `x=0`, `y=0`, `frame_start=0`, `underflow=0`. Counters reset to 0.
- Latency: all outputs except `pix_ready` are registered one cycle after the counter state that produces them. The cycle with `pix_ready=1` at (h,v) is followed by the cycle with `de=1`, `x=h`, `y=v`, `rgb`=that pixel.
- `frame_start` is high in the same cycle as `de` for (0,0).
- No gaps: exactly H_ACTIVE consecutive `de` cycles per active line, and V_ACTIVE active lines per frame.
- The encoders add their own combinational path. This block adds exactly 1 cycle from the handshake to the encoder inputs.

## Configuration
- `DVI_TEST_PATTERN_EN` defined:
  - Adds a `test_mode` input (1 bit).
  - With `test_mode=1`, `pix_ready` is held 0 and `rgb` shows 8 vertical colour bars, each H_ACTIVE/8 wide. Bar order: white, yellow, cyan, green, magenta, red, blue, black.
  - `underflow` never sets in test mode.
- `DVI_TEST_PATTERN_EN` undefined: no `test_mode` port, and the pattern logic is absent.

## Test plan
Small raster for all scenarios: H 4/1/2/1 (H_TOTAL 8), V 3/1/1/1 (V_TOTAL 6), POL 0.

- Release reset, `enable=1`, `pix_valid` always 1 -> `de` high 4 of every 8 cycles on lines 0-2, low on lines 3-5. `hsync` low on h=5,6. `vsync` low for all of line 4. Frame period 48 cycles.
- Feed an incrementing `pix_data` 0x000000.. -> `rgb` equals the transferred word one cycle after each handshake. Frame 0 shows 0x000000..0x00000B in order, with `x`/`y` matching.
- Drop `pix_valid` at pixel (2,1) -> `rgb=0` for that pixel, `underflow=1` and held. Pulse `underflow_clr` -> flag 0. Repeat with clear and underflow in the same cycle -> flag stays 1.
- Deassert `enable` at (3,1) -> next cycle `de=0`, syncs inactive. Reassert -> `frame_start` one cycle after the first `pix_ready`, at x=0, y=0.
- Assert `reset_n=0` asynchronously mid-line -> all outputs at reset values immediately, without waiting for a clock edge.
- With `DVI_TEST_PATTERN_EN` defined and H_ACTIVE=8, `test_mode=1` -> `rgb` = FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000; `pix_ready=0` throughout.
